wf_trigger_conditioner: RTL and testbench

//  Conditions the raw external Waveform trigger pin before it reaches the Waveform block's trigger input.
//  - Synchronises the pin into i_clk and removes glitches.
//  - Selects the active edge and applies a programmable holdoff.
//  - Emits a clean active-low trigger. The Waveform block restarts playback at index 0 on each falling edge of it.
//  - Counts accepted and rejected triggers for PS readback. Config/status connect to AXI4-Lite regs elsewhere.
//

---
 rtl/wf_trigger_conditioner_if.sv | 37 +++
 rtl/wf_trigger_conditioner.sv | 170 +++++++++++++++++
 tb/tb_wf_trigger_conditioner.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wf_trigger_conditioner_if.sv
// Configuration and status bundle for wf_trigger_conditioner.
// The register side (master) drives the configuration and reads back status.
// The conditioner (slave) consumes the configuration and drives status.
//   en        arm the trigger path (0 forces the output idle)
//   edge_sel  00 rising, 01 falling, 10 both, 11 none
//   filt_len  consecutive stable cycles required to accept a level change
//   holdoff   cycles after an accepted trigger during which edges are rejected
//   cnt_clr   one-cycle synchronous clear of both counters
//   trg_lvl   filtered pin level
//   busy      1 while in holdoff
//   acc_cnt   accepted triggers, saturating
//   rej_cnt   edges rejected during holdoff, saturating
interface wf_trigger_conditioner_if #(
   parameter int FILT_W = 16,
   parameter int HOLD_W = 24,
   parameter int CNT_W  = 16
);
   logic              en;
   logic [1:0]        edge_sel;
   logic [FILT_W-1:0] filt_len;
   logic [HOLD_W-1:0] holdoff;
   logic              cnt_clr;
   logic              trg_lvl;
   logic              busy;
   logic [CNT_W-1:0]  acc_cnt;
   logic [CNT_W-1:0]  rej_cnt;

   modport master (
      output en, edge_sel, filt_len, holdoff, cnt_clr,
      input  trg_lvl, busy, acc_cnt, rej_cnt
   );

   modport slave (
      input  en, edge_sel, filt_len, holdoff, cnt_clr,
      output trg_lvl, busy, acc_cnt, rej_cnt
   );
endinterface

// File: rtl/wf_trigger_conditioner.sv
// Conditions the raw external Waveform trigger pin: synchronises it, removes
// glitches, selects the active edge, applies a programmable holdoff and emits
// a clean active-low one-cycle trigger pulse. Accepted and rejected triggers
// are counted for readback.
//   i_clk      system clock
//   i_rst      asynchronous reset, active-low
//   i_trg_pin  raw external trigger pin (asynchronous)
//   cfg        configuration/status bundle (slave side)
//   o_wf_trg   to the Waveform trigger input: idle 1, one-cycle 0 per trigger
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | path disarmed; edges ignored and not counted
// ARMED    | waiting for the selected edge
// HOLDOFF  | trigger just issued; edges are counted as rejected
module wf_trigger_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 16,
   parameter int HOLD_W      = 24,
   parameter int CNT_W       = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_trg_pin,
   wf_trigger_conditioner_if.slave  cfg,
   output logic                     o_wf_trg
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_HOLDOFF = 2'd2;

   localparam logic [1:0] EDGE_RISE  = 2'b00;
   localparam logic [1:0] EDGE_FALL  = 2'b01;
   localparam logic [1:0] EDGE_BOTH  = 2'b10;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_pin;
   logic                   filt_lvl_q, filt_lvl_d;
   logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
   logic                   filt_dly_q;
   logic                   rise, fall, edge_det;
   logic [1:0]             state_q, state_d;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic                   hold_done;
   logic                   accept, reject;
   logic                   wf_trg_q, wf_trg_d;
   logic [CNT_W-1:0]       acc_cnt_q, acc_cnt_d;
   logic [CNT_W-1:0]       rej_cnt_q, rej_cnt_d;

   assign s_pin = sync_q[SYNC_STAGES-1];

   // Level changes only after the synchronised pin has disagreed with the
   // accepted level for more than filt_len consecutive cycles. The counter
   // cannot wrap: once it reaches all-ones it already satisfies the compare.
   always_comb begin
      filt_lvl_d = filt_lvl_q;
      filt_cnt_d = filt_cnt_q;
      if (s_pin == filt_lvl_q) begin
         filt_cnt_d = '0;
      end else if (filt_cnt_q >= cfg.filt_len) begin
         filt_lvl_d = s_pin;
         filt_cnt_d = '0;
      end else begin
         filt_cnt_d = filt_cnt_q + FILT_W'(1);
      end
   end

   assign rise = filt_lvl_q & ~filt_dly_q;
   assign fall = ~filt_lvl_q & filt_dly_q;

   always_comb begin
      case (cfg.edge_sel)
         EDGE_RISE: edge_det = rise;
         EDGE_FALL: edge_det = fall;
         EDGE_BOTH: edge_det = rise | fall;
         default:   edge_det = 1'b0;
      endcase
   end

   // Compared one bit wider so holdoff values of 0 and 1 both end the
   // holdoff after a single cycle, and a holdoff lowered on the fly below
   // the running count still releases immediately.
   assign hold_done = ((HOLD_W+1)'(hold_cnt_q) + (HOLD_W+1)'(1)) >= (HOLD_W+1)'(cfg.holdoff);

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      accept     = 1'b0;
      reject     = 1'b0;
      if (!cfg.en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARMED;
            end
            ST_ARMED: begin
               if (edge_det) begin
                  accept     = 1'b1;
                  hold_cnt_d = '0;
                  state_d    = ST_HOLDOFF;
               end
            end
            ST_HOLDOFF: begin
               reject     = edge_det;
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               if (hold_done) begin
                  state_d = ST_ARMED;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign wf_trg_d = ~accept;

   // Clear wins over increment, except a coincident event leaves a count of 1.
   always_comb begin
      acc_cnt_d = acc_cnt_q;
      if (cfg.cnt_clr) begin
         acc_cnt_d = accept ? CNT_W'(1) : '0;
      end else if (accept && (acc_cnt_q != '1)) begin
         acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      rej_cnt_d = rej_cnt_q;
      if (cfg.cnt_clr) begin
         rej_cnt_d = reject ? CNT_W'(1) : '0;
      end else if (reject && (rej_cnt_q != '1)) begin
         rej_cnt_d = rej_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         sync_q     <= '0;
         filt_lvl_q <= 1'b0;
         filt_cnt_q <= '0;
         filt_dly_q <= 1'b0;
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
         wf_trg_q   <= 1'b1;
         acc_cnt_q  <= '0;
         rej_cnt_q  <= '0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], i_trg_pin};
         filt_lvl_q <= filt_lvl_d;
         filt_cnt_q <= filt_cnt_d;
         filt_dly_q <= filt_lvl_q;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         wf_trg_q   <= wf_trg_d;
         acc_cnt_q  <= acc_cnt_d;
         rej_cnt_q  <= rej_cnt_d;
      end
   end

   assign o_wf_trg    = wf_trg_q;
   assign cfg.trg_lvl = filt_lvl_q;
   assign cfg.busy    = (state_q == ST_HOLDOFF);
   assign cfg.acc_cnt = acc_cnt_q;
   assign cfg.rej_cnt = rej_cnt_q;

endmodule

// File: tb/tb_wf_trigger_conditioner.sv
// Self-checking bench for wf_trigger_conditioner. Counters are built 10 bits
// wide here so saturation is reachable in a short run.
module tb_wf_trigger_conditioner;
   localparam int SYNC = 2;
   localparam int FW   = 16;
   localparam int HW   = 24;
   localparam int CW   = 10;
   localparam int CMAX = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic pin   = 1'b0;
   logic wf;

   wf_trigger_conditioner_if #(.FILT_W(FW), .HOLD_W(HW), .CNT_W(CW)) ifc ();

   wf_trigger_conditioner #(
      .SYNC_STAGES(SYNC), .FILT_W(FW), .HOLD_W(HW), .CNT_W(CW)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst_n),
      .i_trg_pin (pin),
      .cfg       (ifc),
      .o_wf_trg  (wf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   bit m_pipe[$];      // pin samples still in flight through the synchroniser
   bit m_lvl, m_prev;  // accepted level now and one cycle ago
   int m_run;          // cycles the synchronised pin has disagreed with m_lvl
   bit m_armed, m_holding;
   int m_held;         // holdoff cycles elapsed
   int m_acc, m_rej;
   bit m_wf, m_busy;

   task automatic mreset();
      m_pipe.delete();
      for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
      m_lvl = 0; m_prev = 0; m_run = 0;
      m_armed = 0; m_holding = 0; m_held = 0;
      m_acc = 0; m_rej = 0; m_wf = 1; m_busy = 0;
   endtask

   task automatic mstep();
      bit s, rise, fall, ed, acc, rej;
      s = m_pipe.pop_front();
      m_pipe.push_back(pin);
      rise = m_lvl && !m_prev;
      fall = !m_lvl && m_prev;
      case (ifc.edge_sel)
         2'b00:   ed = rise;
         2'b01:   ed = fall;
         2'b10:   ed = rise || fall;
         default: ed = 0;
      endcase
      m_prev = m_lvl;
      if (s == m_lvl) m_run = 0;
      else if (m_run >= int'(ifc.filt_len)) begin m_lvl = s; m_run = 0; end
      else m_run++;
      acc = 0; rej = 0;
      if (!ifc.en) begin
         m_armed = 0; m_holding = 0;
      end else if (m_holding) begin
         rej = ed;
         m_held++;
         if (m_held >= int'(ifc.holdoff)) begin m_holding = 0; m_armed = 1; end
      end else if (m_armed) begin
         if (ed) begin acc = 1; m_armed = 0; m_holding = 1; m_held = 0; end
      end else begin
         m_armed = 1;
      end
      m_wf = !acc;
      m_busy = m_holding;
      if (ifc.cnt_clr) m_acc = acc ? 1 : 0;
      else if (acc && m_acc < CMAX) m_acc++;
      if (ifc.cnt_clr) m_rej = rej ? 1 : 0;
      else if (rej && m_rej < CMAX) m_rej++;
   endtask

   // compare process: every cycle, #1 after the active edge
   always begin
      @(posedge clk);
      if (!rst_n) mreset();
      else mstep();
      #1;
      chk("cyc_wf_trg", 32'(wf), 32'(m_wf));
      chk("cyc_trg_lvl", 32'(ifc.trg_lvl), 32'(m_lvl));
      chk("cyc_busy", 32'(ifc.busy), 32'(m_busy));
      chk("cyc_acc_cnt", 32'(ifc.acc_cnt), 32'(m_acc));
      chk("cyc_rej_cnt", 32'(ifc.rej_cnt), 32'(m_rej));
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic run_cycles(input int n, output int pulses, output int lvl_hi);
      pulses = 0; lvl_hi = 0;
      repeat (n) begin
         @(negedge clk);
         if (!wf) pulses++;
         if (ifc.trg_lvl) lvl_hi++;
      end
   endtask

   // Raises the pin and counts clocks until the pulse; drops the pin after
   // hi_len clocks when hi_len > 0. Gives up after 40 clocks.
   task automatic latency(input int hi_len, output int k);
      pin = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (hi_len > 0 && k == hi_len) pin = 1'b0;
      end while (wf && k < 40);
   endtask

   task automatic clr_pulse();
      ifc.cnt_clr = 1'b1;
      @(negedge clk);
      ifc.cnt_clr = 1'b0;
   endtask

   initial begin
      int p, lh, k;
      ifc.en = 1'b0; ifc.edge_sel = 2'b00; ifc.filt_len = '0;
      ifc.holdoff = '0; ifc.cnt_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_wf_trg", 32'(wf), 32'd1);
      chk("reset_acc", 32'(ifc.acc_cnt), 32'd0);
      chk("reset_busy", 32'(ifc.busy), 32'd0);
      rst_n = 1'b1;

      // 1: basic latency
      ifc.en = 1'b1;
      run_cycles(5, p, lh);
      latency(0, k);
      chk("t1_latency", 32'(k), 32'd4);
      @(negedge clk);
      chk("t1_pulse_width", 32'(wf), 32'd1);
      chk("t1_acc", 32'(ifc.acc_cnt), 32'd1);
      pin = 1'b0;
      run_cycles(10, p, lh);

      // 2: glitch filter
      ifc.filt_len = 16'd10;
      clr_pulse();
      pin = 1'b1;
      run_cycles(5, p, lh);
      pin = 1'b0;
      run_cycles(30, p, lh);
      chk("t2_glitch_pulses", 32'(p), 32'd0);
      chk("t2_glitch_lvl", 32'(lh), 32'd0);
      latency(11, k);
      chk("t2_latency", 32'(k), 32'd14);
      chk("t2_acc", 32'(ifc.acc_cnt), 32'd1);
      run_cycles(30, p, lh);
      ifc.filt_len = '0;

      // 3: holdoff
      ifc.holdoff = 24'd100;
      clr_pulse();
      k = 0;
      for (int e = 0; e < 8; e++) begin
         pin = 1'b1; run_cycles(10, p, lh); k += p;
         pin = 1'b0; run_cycles(20, p, lh); k += p;
      end
      run_cycles(120, p, lh); k += p;
      chk("t3_pulses", 32'(k), 32'd2);
      chk("t3_acc", 32'(ifc.acc_cnt), 32'd2);
      chk("t3_rej", 32'(ifc.rej_cnt), 32'd6);
      chk("t3_busy_end", 32'(ifc.busy), 32'd0);

      // 4: both edges, then none
      ifc.holdoff = '0; ifc.edge_sel = 2'b10;
      clr_pulse();
      k = 0;
      pin = 1'b1; run_cycles(50, p, lh); k += p;
      pin = 1'b0; run_cycles(50, p, lh); k += p;
      pin = 1'b1; run_cycles(50, p, lh); k += p;
      chk("t4_both_pulses", 32'(k), 32'd3);
      ifc.edge_sel = 2'b11;
      k = 0;
      pin = 1'b0; run_cycles(50, p, lh); k += p;
      pin = 1'b1; run_cycles(50, p, lh); k += p;
      pin = 1'b0; run_cycles(50, p, lh); k += p;
      chk("t4_none_pulses", 32'(k), 32'd0);
      chk("t4_acc", 32'(ifc.acc_cnt), 32'd3);

      // 5: disabled path, then arm with pin already high
      ifc.edge_sel = 2'b00; ifc.en = 1'b0;
      clr_pulse();
      k = 0;
      for (int t = 0; t < 6; t++) begin
         pin = ~pin; run_cycles(10, p, lh); k += p;
      end
      chk("t5_dis_pulses", 32'(k), 32'd0);
      chk("t5_dis_acc", 32'(ifc.acc_cnt), 32'd0);
      pin = 1'b1; run_cycles(10, p, lh);
      ifc.en = 1'b1;
      run_cycles(40, p, lh);
      chk("t5_arm_no_pulse", 32'(p), 32'd0);
      pin = 1'b0; run_cycles(10, p, lh);
      pin = 1'b1; run_cycles(10, p, lh);
      chk("t5_next_edge", 32'(p), 32'd1);

      // randomized phase
      begin
         int run;
         run = 0;
         for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ifc.cnt_clr = ($urandom_range(0, 99) == 0);
            if (run == 0) begin
               pin = $urandom_range(0, 1);
               run = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 14);
            end
            run--;
            if ($urandom_range(0, 149) == 0) begin
               ifc.edge_sel = 2'($urandom_range(0, 3));
               ifc.filt_len = 16'($urandom_range(0, 5));
               ifc.holdoff  = 24'($urandom_range(0, 25));
               ifc.en       = ($urandom_range(0, 7) != 0);
            end
         end
         @(negedge clk);
         ifc.cnt_clr = 1'b0; ifc.en = 1'b1;
      end

      // 6: saturation, then clear coincident with an accepted edge
      ifc.edge_sel = 2'b10; ifc.filt_len = '0; ifc.holdoff = '0;
      pin = 1'b0;
      run_cycles(20, p, lh);
      clr_pulse();
      for (int c = 0; c < 2200; c++) begin
         pin = ~pin;
         @(negedge clk);
      end
      chk("t6_acc_sat", 32'(ifc.acc_cnt), 32'(CMAX));
      chk("t6_rej_sat", 32'(ifc.rej_cnt), 32'(CMAX));
      pin = 1'b0;
      ifc.edge_sel = 2'b00;
      run_cycles(10, p, lh);
      chk("t6_acc_hold", 32'(ifc.acc_cnt), 32'(CMAX));
      pin = 1'b1;
      repeat (3) @(negedge clk);
      ifc.cnt_clr = 1'b1;
      @(negedge clk);
      ifc.cnt_clr = 1'b0;
      chk("t6_clr_edge_pulse", 32'(wf), 32'd0);
      chk("t6_clr_edge_acc", 32'(ifc.acc_cnt), 32'd1);
      chk("t6_clr_rej", 32'(ifc.rej_cnt), 32'd0);

      // async reset mid-holdoff
      pin = 1'b0;
      run_cycles(10, p, lh);
      ifc.holdoff = 24'd1000;
      pin = 1'b1;
      run_cycles(20, p, lh);
      chk("rst_pre_busy", 32'(ifc.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_wf_trg", 32'(wf), 32'd1);
      chk("rst_trg_lvl", 32'(ifc.trg_lvl), 32'd0);
      chk("rst_busy", 32'(ifc.busy), 32'd0);
      chk("rst_acc", 32'(ifc.acc_cnt), 32'd0);
      chk("rst_rej", 32'(ifc.rej_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_cycles(20, p, lh);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
